// File: rtl/oam_dma.sv
`timescale 1ns/1ps
// Sprite DMA: on a $4014 write, halts the CPU and copies a 256-byte page
// into OAM starting at the latched OAMADDR, one READ/WRITE pair per byte.
module oam_dma #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_ce,
  input  logic              dma_we,
  input  logic [7:0]        cpu_data_in,
  input  logic [7:0]        oam_addr_in,
  input  logic [7:0]        mem_data_in,
  output logic              cpu_rdy,
  output logic              dma_active,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [7:0]        oam_addr_out,
  output logic [7:0]        oam_data_out,
  output logic              oam_WE,
  output logic              dma_done
);

  typedef enum logic [2:0] {S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE} state_t;

  state_t     state, state_nxt;
  logic [7:0] page, base, idx;
  logic [7:0] idx_rd;
  logic       parity;
  logic       last_byte;

  assign last_byte = (idx == 8'hFF);
  // Byte index the next READ will fetch: WRITE advances to the following byte.
  assign idx_rd    = (state == S_WRITE) ? idx + 8'd1 : idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      state <= S_IDLE;
    else if (cpu_ce) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (dma_we) state_nxt = S_HALT;
      S_HALT:  state_nxt = parity ? S_ALIGN : S_READ;
      S_ALIGN: state_nxt = S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_byte ? S_IDLE : S_READ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_rdy    = (state == S_IDLE);
    dma_active = (state != S_IDLE);
    oam_WE     = (state == S_WRITE) && cpu_ce;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity       <= 1'b0;
      page         <= 8'h00;
      base         <= 8'h00;
      idx          <= 8'h00;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      oam_addr_out <= 8'h00;
      oam_data_out <= 8'h00;
      dma_done     <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      if (cpu_ce) begin
        parity <= ~parity;
        // Read address is registered so it is stable for the whole READ cycle.
        mem_rd <= (state_nxt == S_READ);
        if (state_nxt == S_READ) mem_addr <= ADDR_W'({page, idx_rd});
        case (state)
          S_IDLE: begin
            if (dma_we) begin
              page <= cpu_data_in;
              base <= oam_addr_in;
              idx  <= 8'h00;
            end
          end
          S_READ: begin
            oam_data_out <= mem_data_in;
            oam_addr_out <= base + idx;
          end
          S_WRITE: begin
            if (last_byte) dma_done <= 1'b1;
            else           idx      <= idx + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for oam_dma: stimulus pushes the expected OAM
// write stream per transfer, a negedge monitor pops and compares.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_ce = 1'b0;
  logic        dma_we = 1'b0;
  logic [7:0]  cpu_data_in = 8'h00;
  logic [7:0]  oam_addr_in = 8'h00;
  logic [7:0]  mem_data_in;
  logic        cpu_rdy, dma_active, mem_rd, oam_WE, dma_done;
  logic [15:0] mem_addr;
  logic [7:0]  oam_addr_out, oam_data_out;

  logic [7:0]  mem [0:65535];

  oam_dma #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .dma_we(dma_we),
    .cpu_data_in(cpu_data_in), .oam_addr_in(oam_addr_in), .mem_data_in(mem_data_in),
    .cpu_rdy(cpu_rdy), .dma_active(dma_active), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .oam_addr_out(oam_addr_out), .oam_data_out(oam_data_out), .oam_WE(oam_WE),
    .dma_done(dma_done)
  );

  assign mem_data_in = mem[mem_addr];

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver shared state
  int         gap = 1;
  int         ce_cnt = 0;
  int         req_seq = 0;
  int         srv_seq = 0;
  logic [7:0] req_page = 8'h00;
  logic [7:0] req_base = 8'h00;
  int         req_par = -1;

  // Scoreboard state
  logic [15:0] wq[$];
  int          lq[$];
  logic [7:0]  exp_page = 8'h00;
  int          len_cnt = 0, nrw_cnt = 0, rd_cnt = 0, done_cnt = 0;

  // Driver: owns cpu_ce / dma_we / data inputs. ce_cnt mirrors the number of
  // enabled edges since reset, i.e. the DUT's parity bit.
  initial begin
    int gc;
    gc = 0;
    forever begin
      @(posedge clk);
      if (!reset) ce_cnt = 0;
      else if (cpu_ce) ce_cnt++;
      #1;
      dma_we      = 1'b0;
      cpu_data_in = 8'($urandom);
      oam_addr_in = 8'($urandom);
      cpu_ce      = (gc == 0);
      gc          = (gc + 1 >= gap) ? 0 : gc + 1;
      if (cpu_ce && srv_seq != req_seq &&
          (req_par < 0 || ((ce_cnt + 1) % 2) == req_par)) begin
        dma_we      = 1'b1;
        cpu_data_in = req_page;
        oam_addr_in = req_base;
        srv_seq     = req_seq;
      end
    end
  end

  // Monitor
  initial begin
    logic [15:0] e;
    int a;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (oam_WE) begin
          total++;
          $display("FAIL we_in_reset: oam_WE=1 expected 0");
        end
        wq.delete();
        lq.delete();
        len_cnt = 0; nrw_cnt = 0; rd_cnt = 0;
      end else begin
        check("dma_active_vs_rdy", dma_active, !cpu_rdy);
        if (oam_WE) begin
          check("we_with_ce", cpu_ce, 1);
          if (wq.size() == 0) begin
            total++;
            $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                     oam_addr_out, oam_data_out);
          end else begin
            e = wq.pop_front();
            check("oam_addr", oam_addr_out, e[15:8]);
            check("oam_data", oam_data_out, e[7:0]);
          end
        end
        if (mem_rd) check("rd_page", mem_addr[15:8], exp_page);
        if (cpu_ce && !cpu_rdy) begin
          len_cnt++;
          if (mem_rd) rd_cnt++;
          else if (!oam_WE) nrw_cnt++;
        end
        if (dma_done) begin
          done_cnt++;
          if (lq.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: dma_done=1 expected 0");
          end else begin
            a = lq.pop_front();
            check("halt_len", len_cnt, 513 + a);
            check("halt_align_cycles", nrw_cnt, 1 + a);
            check("read_cycles", rd_cnt, 256);
          end
          len_cnt = 0; nrw_cnt = 0; rd_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic [7:0] pg, input logic [7:0] bs, input int par);
    for (int i = 0; i < 256; i++) wq.push_back({bs + i[7:0], mem[{pg, i[7:0]}]});
    lq.push_back(par);
    exp_page = pg;
    req_page = pg;
    req_base = bs;
    req_par  = par;
    req_seq++;
  endtask

  task automatic wait_served(input string name);
    int t;
    t = 0;
    while (srv_seq != req_seq && t < 100) begin @(negedge clk); t++; end
    if (srv_seq != req_seq) begin
      total++;
      $display("FAIL %s_serve_timeout: request not accepted in %0d clks", name, t);
      srv_seq = req_seq;
    end
  endtask

  task automatic wait_rd_byte(input string name, input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (!(mem_rd && mem_addr[7:0] == b) && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) begin
      total++;
      $display("FAIL %s_read_timeout: byte %0h never read", name, b);
    end
  endtask

  task automatic run_dma(input string name, input logic [7:0] pg, input logic [7:0] bs,
                         input int par, input bit reentry);
    int d0, t;
    d0 = done_cnt;
    issue(pg, bs, par);
    wait_served(name);
    if (reentry) begin
      wait_rd_byte(name, 8'd100);
      req_page = 8'h07;
      req_base = 8'($urandom);
      req_par  = -1;
      req_seq++;
      wait_served(name);
    end
    t = 0;
    @(negedge clk);
    while (!(dma_active == 1'b0 && done_cnt != d0) && t < 5000) begin @(negedge clk); t++; end
    if (t >= 5000) begin
      total++;
      $display("FAIL %s_done_timeout: dma_done count %0d expected %0d", name, done_cnt, d0 + 1);
    end
    repeat (8) @(negedge clk);
    check({name, "_done_count"}, done_cnt, d0 + 1);
    check({name, "_queue_drained"}, wq.size(), 0);
    check({name, "_rdy_after"}, cpu_rdy, 1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_cpu_rdy"}, cpu_rdy, 1);
    check({name, "_dma_active"}, dma_active, 0);
    check({name, "_mem_addr"}, mem_addr, 0);
    check({name, "_mem_rd"}, mem_rd, 0);
    check({name, "_oam_addr"}, oam_addr_out, 0);
    check({name, "_oam_data"}, oam_data_out, 0);
    check({name, "_oam_we"}, oam_WE, 0);
    check({name, "_dma_done"}, dma_done, 0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #3 reset = 1'b1;
    repeat (4) @(negedge clk);

    run_dma("even", 8'h02, 8'h00, 0, 1'b0);
    run_dma("odd", 8'h02, 8'h00, 1, 1'b0);
    run_dma("wrap", 8'h03, 8'hF0, int'($urandom_range(0, 1)), 1'b0);
    run_dma("reentry", 8'h02, 8'h00, 0, 1'b1);
    for (int k = 0; k < 2; k++)
      run_dma("random", 8'($urandom), 8'($urandom), int'($urandom_range(0, 1)), 1'b0);

    // Abort during READ of byte 37
    issue(8'h02, 8'h00, 0);
    wait_served("abort");
    wait_rd_byte("abort", 8'd37);
    #1 reset = 1'b0;
    #1 check_reset_vals("abort");
    repeat (5) @(negedge clk);
    @(posedge clk); #3 reset = 1'b1;
    @(negedge clk);
    check("abort_rdy_released", cpu_rdy, 1);
    check("abort_idle", dma_active, 0);
    repeat (20) @(negedge clk);
    check("abort_no_done", dma_done, 0);

    run_dma("post_reset", 8'($urandom), 8'($urandom), 1, 1'b0);

    gap = 3;
    repeat (4) @(negedge clk);
    run_dma("ce_gap", 8'h02, 8'h00, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
